dvi_timing_sequencer: RTL

//  Video timing master for the DVI encoder: produces hsync/vsync/de, plus a lead-timed pixel fetch

---
 rtl/dvi_timing_sequencer.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/dvi_timing_sequencer.sv
// -----------------------------------------------------------------------------
// dvi_timing_sequencer
//
// Video timing master for a DVI encoder. Generates hsync/vsync/de from a
// raster counter pair and, from a second "lookahead" counter pair running
// FETCH_LEAD steps ahead, a pixel fetch strobe with coordinates so that the
// upstream pixel source can present rgb in step with de. A start/stop
// handshake guarantees raster output only begins and ends on whole frames.
//
// Ports
//   clk_pixel   in   pixel clock, the only clock
//   reset_n     in   asynchronous active-low reset
//   enable      in   level request to run the raster
//   hsync       out  horizontal sync (active level HSYNC_POL)
//   vsync       out  vertical sync (active level VSYNC_POL)
//   de          out  data enable
//   fetch_req   out  pixel fetch strobe, FETCH_LEAD cycles ahead of de
//   fetch_x     out  column of the pixel being fetched
//   fetch_y     out  row of the pixel being fetched
//   frame_start out  one-cycle pulse together with de of pixel (0,0)
//   busy        out  high while priming, running or draining
// -----------------------------------------------------------------------------
module dvi_timing_sequencer #(
    parameter int H_ACTIVE   = 720,
    parameter int H_FP       = 12,
    parameter int H_SYNC     = 64,
    parameter int H_BP       = 68,
    parameter int V_ACTIVE   = 576,
    parameter int V_FP       = 5,
    parameter int V_SYNC     = 5,
    parameter int V_BP       = 39,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int FETCH_LEAD = 2
) (
    input  logic        clk_pixel,
    input  logic        reset_n,
    input  logic        enable,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        fetch_req,
    output logic [11:0] fetch_x,
    output logic [11:0] fetch_y,
    output logic        frame_start,
    output logic        busy
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_ACT_C   = 12'(H_ACTIVE);
    localparam logic [11:0] H_SS_C    = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SE_C    = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_END_C   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_ACT_C   = 12'(V_ACTIVE);
    localparam logic [11:0] V_SS_C    = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SE_C    = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] V_END_C   = 12'(V_TOTAL - 1);
    localparam logic [11:0] LEAD_END_C = 12'(FETCH_LEAD - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] h_q, h_d, v_q, v_d;
    logic [11:0] hl_q, hl_d, vl_q, vl_d;
    logic [11:0] prime_q, prime_d;
    // Set while the lookahead has already wrapped into the next frame but the
    // raster has not; fetches in that window belong to the next frame.
    logic        la_ahead_q, la_ahead_d;

    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        de_q, de_d;
    logic        fetch_req_q, fetch_req_d;
    logic [11:0] fetch_x_q, fetch_x_d;
    logic [11:0] fetch_y_q, fetch_y_d;
    logic        frame_start_q, frame_start_d;
    logic        busy_q, busy_d;

    logic        h_end_s, v_end_s, frame_end_s;
    logic        hl_end_s, vl_end_s, la_wrap_s;
    logic [11:0] h_nxt_s, v_nxt_s, hl_nxt_s, vl_nxt_s;
    logic        raster_on_s, fetch_on_s, la_active_s, fetch_block_s;

    // Counter wrap detection and next-step positions for both counter pairs.
    always_comb begin
        h_end_s     = (h_q == H_END_C);
        v_end_s     = (v_q == V_END_C);
        frame_end_s = h_end_s && v_end_s;
        h_nxt_s     = h_end_s ? 12'd0 : h_q + 12'd1;
        if (h_end_s) begin
            v_nxt_s = v_end_s ? 12'd0 : v_q + 12'd1;
        end else begin
            v_nxt_s = v_q;
        end
        hl_end_s  = (hl_q == H_END_C);
        vl_end_s  = (vl_q == V_END_C);
        la_wrap_s = hl_end_s && vl_end_s;
        hl_nxt_s  = hl_end_s ? 12'd0 : hl_q + 12'd1;
        if (hl_end_s) begin
            vl_nxt_s = vl_end_s ? 12'd0 : vl_q + 12'd1;
        end else begin
            vl_nxt_s = vl_q;
        end
    end

    // Sequencer next state and counter updates.
    always_comb begin
        state_d    = state_q;
        h_d        = h_q;
        v_d        = v_q;
        hl_d       = hl_q;
        vl_d       = vl_q;
        prime_d    = prime_q;
        la_ahead_d = la_ahead_q;
        case (state_q)
            ST_IDLE: begin
                h_d        = 12'd0;
                v_d        = 12'd0;
                hl_d       = 12'd0;
                vl_d       = 12'd0;
                prime_d    = 12'd0;
                la_ahead_d = 1'b0;
                if (enable) begin
                    state_d = ST_PRIME;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRIME: begin
                hl_d       = hl_nxt_s;
                vl_d       = vl_nxt_s;
                h_d        = 12'd0;
                v_d        = 12'd0;
                la_ahead_d = 1'b0;
                if (prime_q == LEAD_END_C) begin
                    state_d = ST_RUN;
                    prime_d = 12'd0;
                end else begin
                    state_d = ST_PRIME;
                    prime_d = prime_q + 12'd1;
                end
            end
            ST_RUN, ST_DRAIN: begin
                h_d  = h_nxt_s;
                v_d  = v_nxt_s;
                hl_d = hl_nxt_s;
                vl_d = vl_nxt_s;
                if (la_wrap_s) begin
                    la_ahead_d = 1'b1;
                end else if (frame_end_s) begin
                    la_ahead_d = 1'b0;
                end else begin
                    la_ahead_d = la_ahead_q;
                end
                // enable only decides anything at the frame boundary; in RUN a
                // low enable merely moves to DRAIN so the frame completes.
                if (frame_end_s) begin
                    if (enable) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d    = ST_IDLE;
                        h_d        = 12'd0;
                        v_d        = 12'd0;
                        hl_d       = 12'd0;
                        vl_d       = 12'd0;
                        la_ahead_d = 1'b0;
                    end
                end else if (!enable) begin
                    state_d = ST_DRAIN;
                end else if (state_q == ST_RUN) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                h_d        = 12'd0;
                v_d        = 12'd0;
                hl_d       = 12'd0;
                vl_d       = 12'd0;
                prime_d    = 12'd0;
                la_ahead_d = 1'b0;
            end
        endcase
    end

    // Output values to be registered from the current raster/lookahead position.
    always_comb begin
        raster_on_s   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        fetch_on_s    = raster_on_s || (state_q == ST_PRIME);
        la_active_s   = (hl_q < H_ACT_C) && (vl_q < V_ACT_C);
        // While draining, fetches for the next frame are dropped unless enable
        // has come back, which signals the raster will continue into it.
        fetch_block_s = (state_q == ST_DRAIN) && la_ahead_q && !enable;

        if (raster_on_s && (h_q >= H_SS_C) && (h_q < H_SE_C)) begin
            hsync_d = HSYNC_POL;
        end else begin
            hsync_d = ~HSYNC_POL;
        end
        if (raster_on_s && (v_q >= V_SS_C) && (v_q < V_SE_C)) begin
            vsync_d = VSYNC_POL;
        end else begin
            vsync_d = ~VSYNC_POL;
        end
        de_d          = raster_on_s && (h_q < H_ACT_C) && (v_q < V_ACT_C);
        frame_start_d = raster_on_s && (h_q == 12'd0) && (v_q == 12'd0);
        fetch_req_d   = fetch_on_s && la_active_s && !fetch_block_s;
        if (fetch_on_s) begin
            fetch_x_d = hl_q;
            fetch_y_d = vl_q;
        end else begin
            fetch_x_d = 12'd0;
            fetch_y_d = 12'd0;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            h_q           <= 12'd0;
            v_q           <= 12'd0;
            hl_q          <= 12'd0;
            vl_q          <= 12'd0;
            prime_q       <= 12'd0;
            la_ahead_q    <= 1'b0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            de_q          <= 1'b0;
            fetch_req_q   <= 1'b0;
            fetch_x_q     <= 12'd0;
            fetch_y_q     <= 12'd0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_q           <= h_d;
            v_q           <= v_d;
            hl_q          <= hl_d;
            vl_q          <= vl_d;
            prime_q       <= prime_d;
            la_ahead_q    <= la_ahead_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            fetch_req_q   <= fetch_req_d;
            fetch_x_q     <= fetch_x_d;
            fetch_y_q     <= fetch_y_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign fetch_req   = fetch_req_q;
    assign fetch_x     = fetch_x_q;
    assign fetch_y     = fetch_y_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;

endmodule
